avg_threshold_detector: RTL and testbench
=========================================

Name: avg_threshold_detector

Overview:
- Downstream stage of the moving-average filter. Consumes the filtered sample and its output strobe (filter dout / output_pulse).
- Applies a two-threshold hysteresis comparator with consecutive-sample debounce and emits one-cycle rise/fall event pulses plus a level flag.
- Tracks running peak maximum and minimum of the filtered stream, clearable by software.

Parameters:
- DATA_WIDTH, 16, width of signed sample and thresholds
- CNT_WIDTH, 4, width of debounce confirm count and internal counter

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- enable  in  1  block enable; low freezes all state
- sample_valid  in  1  strobe, one cycle per new filtered sample (filter output_pulse)
- sample  in  DATA_WIDTH  signed filtered sample (filter dout)
- thr_high  in  DATA_WIDTH  signed rise threshold
- thr_low  in  DATA_WIDTH  signed fall threshold
- confirm_cnt  in  CNT_WIDTH  consecutive qualifying samples needed; 0 treated as 1
- clear_peaks  in  1  re-initialise peak tracking
- level_high  out  1  debounced comparator state
- rise_pulse  out  1  one-cycle event, LOW->HIGH confirmed
- fall_pulse  out  1  one-cycle event, HIGH->LOW confirmed
- peak_max  out  DATA_WIDTH  signed running maximum
- peak_min  out  DATA_WIDTH  signed running minimum
- peaks_valid  out  1  at least one sample since reset/clear

Behaviour:
- Reset: FSM=LOW, counter=0, level_high=0, rise_pulse=0, fall_pulse=0, peak_max=most-negative (0x8000 at 16b), peak_min=most-positive (0x7FFF), peaks_valid=0.
- A sample "qualifies" only when enable=1 and sample_valid=1. Signed compare: above = sample > thr_high; below = sample < thr_low (strict).
- FSM states: LOW, RISE_PEND, HIGH, FALL_PEND. eff_cnt = max(confirm_cnt,1).
- LOW: qualifying sample with above -> if eff_cnt==1 go HIGH and pulse rise, else RISE_PEND with counter=1. Otherwise stay.
- RISE_PEND: qualifying sample with above -> counter+1; when counter+1 == eff_cnt go HIGH, pulse rise, counter=0. Qualifying sample without above -> LOW, counter=0. No qualifying sample -> hold.
- HIGH / FALL_PEND: mirror image using below, fall_pulse, return to HIGH on non-below.
- level_high=1 in HIGH and FALL_PEND, 0 in LOW and RISE_PEND. Registered output.
- Latency: rise/fall_pulse and level_high change in the cycle after the confirming sample's clock edge (1 clk). Pulses last exactly one cycle and are cleared every other cycle, including while enable=0.
- Misconfiguration (thr_low > thr_high): no special handling. Only the condition relevant to the current state is evaluated, so no oscillation occurs within one sample.
- confirm_cnt changing mid-pend: compare against the current value. If counter already >= eff_cnt, the next qualifying sample confirms.
- Peaks: on a qualifying sample, peak_max=max(peak_max,sample) and peak_min=min(peak_min,sample); peaks_valid=1.
- clear_peaks (level, sampled when enable=1) restores the reset peak values and peaks_valid=0.
  - clear_peaks with a qualifying sample in the same cycle: both peaks load that sample and peaks_valid=1.
  - clear_peaks does not affect the FSM.
- enable=0: FSM, counter and peaks hold. sample_valid is ignored.
- Counter saturates at all-ones; no wrap.
- Reset asserted mid-pend returns immediately (async) to the reset values above.

Decomposition:
- Shared package: FSM state enum (LOW, RISE_PEND, HIGH, FALL_PEND), signed min/max constants derived from DATA_WIDTH.
- One sub-module is natural: avg_peak_tracker, holding the peak_max/peak_min/peaks_valid registers and clear logic. The FSM and debounce logic stay in the top module.

Test Plan:
- Reset, then thr_high=100, thr_low=-100, confirm_cnt=3. Samples 150,150,150 -> rise_pulse single cycle one clk after 3rd sample; level_high=1.
- Same config, samples 150,150,50,150 -> no rise_pulse, level_high stays 0, FSM returns LOW after 50.
- From HIGH with confirm_cnt=0, one sample -150 -> fall_pulse immediately after that sample; boundary sample exactly -100 -> no transition (strict compare).
- sample_valid gaps and enable=0 between qualifying samples 150,[idle 5 clk],150,150 with confirm_cnt=3 -> rise still confirmed on 3rd sample; no pulse during enable=0.
- Peaks: samples 10,-20,300,5 -> peak_max=300, peak_min=-20, peaks_valid=1. Then clear_peaks together with sample 7 -> peak_max=peak_min=7. Then clear_peaks alone -> 0x8000/0x7FFF, peaks_valid=0.
- Assert rst_n low during RISE_PEND (counter=2) -> all outputs to reset values asynchronously. After release, 2 samples of 150 with confirm_cnt=3 -> no rise.

Source files
------------

// File: rtl/avg_threshold_detector_pkg.sv
// Shared types and constants for the averaged-sample threshold detector.
// Holds the comparator state encoding and the signed range helpers.
package avg_threshold_detector_pkg;

    localparam int DEF_DATA_WIDTH = 16;
    localparam int DEF_CNT_WIDTH  = 4;

    typedef enum logic [1:0] {
        ST_LOW       = 2'd0,
        ST_RISE_PEND = 2'd1,
        ST_HIGH      = 2'd2,
        ST_FALL_PEND = 2'd3
    } det_state_t;

    // Most-negative / most-positive two's-complement values for a w-bit sample.
    function automatic logic signed [63:0] sample_min(input int w);
        sample_min = -(64'sd1 <<< (w - 1));
    endfunction

    function automatic logic signed [63:0] sample_max(input int w);
        sample_max = (64'sd1 <<< (w - 1)) - 64'sd1;
    endfunction

endpackage

// File: rtl/avg_threshold_detector_if.sv
// Sample stream, configuration and result bundle for the threshold detector.
// master = sample source / software side, slave = detector.
interface avg_threshold_detector_if #(
    parameter int DATA_WIDTH = 16,
    parameter int CNT_WIDTH  = 4
);
    logic                         enable;
    logic                         sample_valid;
    logic signed [DATA_WIDTH-1:0] sample;
    logic signed [DATA_WIDTH-1:0] thr_high;
    logic signed [DATA_WIDTH-1:0] thr_low;
    logic        [CNT_WIDTH-1:0]  confirm_cnt;
    logic                         clear_peaks;
    logic                         level_high;
    logic                         rise_pulse;
    logic                         fall_pulse;
    logic signed [DATA_WIDTH-1:0] peak_max;
    logic signed [DATA_WIDTH-1:0] peak_min;
    logic                         peaks_valid;

    modport master (
        output enable, sample_valid, sample, thr_high, thr_low, confirm_cnt, clear_peaks,
        input  level_high, rise_pulse, fall_pulse, peak_max, peak_min, peaks_valid
    );

    modport slave (
        input  enable, sample_valid, sample, thr_high, thr_low, confirm_cnt, clear_peaks,
        output level_high, rise_pulse, fall_pulse, peak_max, peak_min, peaks_valid
    );
endinterface

// File: rtl/avg_peak_tracker.sv
// Running signed max/min of qualifying samples with software clear.
// Latency 1 clk; no backpressure, enable=0 freezes all registers.
// Clear is a level sampled while enabled; a same-cycle sample seeds both peaks.
module avg_peak_tracker
    import avg_threshold_detector_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         enable,
    input  logic                         sample_valid,
    input  logic                         clear_peaks,
    input  logic signed [DATA_WIDTH-1:0] sample,
    output logic signed [DATA_WIDTH-1:0] peak_max,
    output logic signed [DATA_WIDTH-1:0] peak_min,
    output logic                         peaks_valid
);

    localparam logic signed [DATA_WIDTH-1:0] PEAK_FLOOR = DATA_WIDTH'(sample_min(DATA_WIDTH));
    localparam logic signed [DATA_WIDTH-1:0] PEAK_CEIL  = DATA_WIDTH'(sample_max(DATA_WIDTH));

    logic qual;
    assign qual = enable && sample_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            peak_max    <= PEAK_FLOOR;
            peak_min    <= PEAK_CEIL;
            peaks_valid <= 1'b0;
        end else if (enable) begin
            if (clear_peaks) begin
                peak_max    <= qual ? sample : PEAK_FLOOR;
                peak_min    <= qual ? sample : PEAK_CEIL;
                peaks_valid <= qual;
            end else if (qual) begin
                if (sample > peak_max) peak_max <= sample;
                if (sample < peak_min) peak_min <= sample;
                peaks_valid <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/avg_threshold_detector.sv
// Hysteresis comparator with consecutive-sample debounce on the filtered stream.
// Latency 1 clk from confirming sample to level/pulse; no backpressure, enable=0 holds state.
// Also tracks running signed peaks via avg_peak_tracker.
module avg_threshold_detector
    import avg_threshold_detector_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int CNT_WIDTH  = DEF_CNT_WIDTH
) (
    input  logic                     clk,
    input  logic                     rst_n,
    avg_threshold_detector_if.slave  bus
);

    det_state_t           state_q, state_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 rise_d, fall_d;
    logic                 rise_q, fall_q, level_q;

    logic                 qual, above, below;
    logic [CNT_WIDTH-1:0] eff_cnt;
    logic [CNT_WIDTH:0]   cnt_inc;
    logic [CNT_WIDTH-1:0] cnt_sat;
    logic                 confirm, eff_is_one;

    assign qual       = bus.enable && bus.sample_valid;
    assign above      = bus.sample > bus.thr_high;
    assign below      = bus.sample < bus.thr_low;
    assign eff_cnt    = (bus.confirm_cnt == '0) ? CNT_WIDTH'(1) : bus.confirm_cnt;
    assign eff_is_one = (eff_cnt == CNT_WIDTH'(1));
    // Extra bit keeps the compare exact even when the counter already exceeds a lowered target.
    assign cnt_inc    = {1'b0, cnt_q} + (CNT_WIDTH + 1)'(1);
    assign confirm    = (cnt_inc >= {1'b0, eff_cnt});
    assign cnt_sat    = (cnt_q == '1) ? cnt_q : cnt_inc[CNT_WIDTH-1:0];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        case (state_q)
            ST_LOW: begin
                if (qual && above) begin
                    if (eff_is_one) begin
                        state_d = ST_HIGH;
                        rise_d  = 1'b1;
                    end else begin
                        state_d = ST_RISE_PEND;
                        cnt_d   = CNT_WIDTH'(1);
                    end
                end
            end
            ST_RISE_PEND: begin
                if (qual) begin
                    if (!above) begin
                        state_d = ST_LOW;
                        cnt_d   = '0;
                    end else if (confirm) begin
                        state_d = ST_HIGH;
                        rise_d  = 1'b1;
                        cnt_d   = '0;
                    end else begin
                        cnt_d   = cnt_sat;
                    end
                end
            end
            ST_HIGH: begin
                if (qual && below) begin
                    if (eff_is_one) begin
                        state_d = ST_LOW;
                        fall_d  = 1'b1;
                    end else begin
                        state_d = ST_FALL_PEND;
                        cnt_d   = CNT_WIDTH'(1);
                    end
                end
            end
            ST_FALL_PEND: begin
                if (qual) begin
                    if (!below) begin
                        state_d = ST_HIGH;
                        cnt_d   = '0;
                    end else if (confirm) begin
                        state_d = ST_LOW;
                        fall_d  = 1'b1;
                        cnt_d   = '0;
                    end else begin
                        cnt_d   = cnt_sat;
                    end
                end
            end
            default: begin
                state_d = ST_LOW;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_LOW;
            cnt_q   <= '0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
            level_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            level_q <= (state_d == ST_HIGH) || (state_d == ST_FALL_PEND);
        end
    end

    assign bus.level_high = level_q;
    assign bus.rise_pulse = rise_q;
    assign bus.fall_pulse = fall_q;

    logic signed [DATA_WIDTH-1:0] pk_max, pk_min;
    logic                         pk_vld;

    avg_peak_tracker #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_peak (
        .clk          (clk),
        .rst_n        (rst_n),
        .enable       (bus.enable),
        .sample_valid (bus.sample_valid),
        .clear_peaks  (bus.clear_peaks),
        .sample       (bus.sample),
        .peak_max     (pk_max),
        .peak_min     (pk_min),
        .peaks_valid  (pk_vld)
    );

    assign bus.peak_max    = pk_max;
    assign bus.peak_min    = pk_min;
    assign bus.peaks_valid = pk_vld;

endmodule

// File: tb/tb_avg_threshold_detector.sv
// Scoreboarded bench for avg_threshold_detector: directed scenarios then random traffic.
module tb_avg_threshold_detector;

    localparam int DW = 16;
    localparam int CW = 4;
    localparam int MOST_NEG = -32768;
    localparam int MOST_POS = 32767;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    avg_threshold_detector_if #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) bus ();

    avg_threshold_detector #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        bit level;
        bit rise;
        bit fall;
        int pmax;
        int pmin;
        bit pvalid;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   cycle_no = 0;

    // Reference model: debounced level plus count of consecutive qualifying samples
    // that argue for the opposite level.
    bit m_level;
    int m_run;
    int m_pmax, m_pmin;
    bit m_pvalid;

    task automatic model_reset();
        m_level  = 1'b0;
        m_run    = 0;
        m_pmax   = MOST_NEG;
        m_pmin   = MOST_POS;
        m_pvalid = 1'b0;
    endtask

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic chk_reset(input string name);
        chk({name, ".level_high"},  int'(bus.level_high), 0);
        chk({name, ".rise_pulse"},  int'(bus.rise_pulse), 0);
        chk({name, ".fall_pulse"},  int'(bus.fall_pulse), 0);
        chk({name, ".peak_max"},    int'(bus.peak_max), MOST_NEG);
        chk({name, ".peak_min"},    int'(bus.peak_min), MOST_POS);
        chk({name, ".peaks_valid"}, int'(bus.peaks_valid), 0);
    endtask

    // Drive one cycle, predict outputs after the edge, push the prediction.
    task automatic step(input bit en, input bit vld, input int s, input bit clr);
        exp_t e;
        bit   qual, cond;
        int   eff;
        bus.enable       = en;
        bus.sample_valid = vld;
        bus.sample       = 16'(s);
        bus.clear_peaks  = clr;
        qual = en && vld;
        eff  = (bus.confirm_cnt == 0) ? 1 : int'(bus.confirm_cnt);
        e.rise = 1'b0;
        e.fall = 1'b0;
        if (qual) begin
            cond = m_level ? (s < int'(bus.thr_low)) : (s > int'(bus.thr_high));
            if (cond) begin
                m_run++;
                if (m_run >= eff) begin
                    m_level = !m_level;
                    m_run   = 0;
                    if (m_level) e.rise = 1'b1;
                    else         e.fall = 1'b1;
                end
            end else begin
                m_run = 0;
            end
        end
        if (en) begin
            if (clr) begin
                m_pmax   = qual ? s : MOST_NEG;
                m_pmin   = qual ? s : MOST_POS;
                m_pvalid = qual;
            end else if (qual) begin
                if (s > m_pmax) m_pmax = s;
                if (s < m_pmin) m_pmin = s;
                m_pvalid = 1'b1;
            end
        end
        e.level  = m_level;
        e.pmax   = m_pmax;
        e.pmin   = m_pmin;
        e.pvalid = m_pvalid;
        @(posedge clk);
        exp_q.push_back(e);
        #1;
    endtask

    exp_t got;
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            got = exp_q.pop_front();
            cycle_no++;
            checks++;
            if (bus.level_high !== got.level || bus.rise_pulse !== got.rise ||
                bus.fall_pulse !== got.fall || int'(bus.peak_max) != got.pmax ||
                int'(bus.peak_min) != got.pmin || bus.peaks_valid !== got.pvalid) begin
                failures++;
                $display("FAIL scoreboard cycle %0d: got lvl=%0b rise=%0b fall=%0b max=%0d min=%0d pv=%0b expected lvl=%0b rise=%0b fall=%0b max=%0d min=%0d pv=%0b",
                         cycle_no, bus.level_high, bus.rise_pulse, bus.fall_pulse,
                         int'(bus.peak_max), int'(bus.peak_min), bus.peaks_valid,
                         got.level, got.rise, got.fall, got.pmax, got.pmin, got.pvalid);
            end
        end
    end

    initial begin
        bus.enable       = 1'b0;
        bus.sample_valid = 1'b0;
        bus.sample       = '0;
        bus.thr_high     = 16'sd100;
        bus.thr_low      = -16'sd100;
        bus.confirm_cnt  = 4'd3;
        bus.clear_peaks  = 1'b0;
        model_reset();
        #12;
        chk_reset("reset");
        rst_n = 1'b1;

        // Three consecutive above-threshold samples confirm a rise.
        step(1, 1, 150, 0);
        chk("t1.no_early_rise", int'(bus.rise_pulse), 0);
        step(1, 1, 150, 0);
        step(1, 1, 150, 0);
        chk("t1.rise_pulse", int'(bus.rise_pulse), 1);
        chk("t1.level_high", int'(bus.level_high), 1);
        step(1, 0, 0, 0);
        chk("t1.rise_one_cycle", int'(bus.rise_pulse), 0);

        // From HIGH with confirm_cnt=0: boundary value holds, one -150 falls.
        bus.confirm_cnt = 4'd0;
        step(1, 1, -100, 0);
        chk("t3.boundary_level", int'(bus.level_high), 1);
        chk("t3.boundary_nofall", int'(bus.fall_pulse), 0);
        step(1, 1, -150, 0);
        chk("t3.fall_pulse", int'(bus.fall_pulse), 1);
        chk("t3.level_low", int'(bus.level_high), 0);

        // Interrupted run: 150,150,50,150 never confirms.
        bus.confirm_cnt = 4'd3;
        step(1, 1, 150, 0);
        step(1, 1, 150, 0);
        step(1, 1, 50, 0);
        step(1, 1, 150, 0);
        chk("t2.no_rise", int'(bus.rise_pulse), 0);
        chk("t2.level_low", int'(bus.level_high), 0);
        step(1, 1, 0, 0);

        // Gaps and enable=0 between qualifying samples still count as consecutive.
        step(1, 1, 150, 0);
        step(0, 1, 150, 0);
        step(1, 0, 999, 0);
        step(0, 0, -500, 0);
        step(0, 1, -500, 0);
        step(1, 0, -500, 0);
        chk("t4.no_pulse_idle", int'(bus.rise_pulse), 0);
        step(1, 1, 150, 0);
        step(1, 1, 150, 0);
        chk("t4.rise_pulse", int'(bus.rise_pulse), 1);
        bus.confirm_cnt = 4'd0;
        step(1, 1, -150, 0);

        // Peak tracking and clear behaviour.
        bus.confirm_cnt = 4'd3;
        step(1, 0, 0, 1);
        chk("t5.cleared_valid", int'(bus.peaks_valid), 0);
        step(1, 1, 10, 0);
        step(1, 1, -20, 0);
        step(1, 1, 300, 0);
        step(1, 1, 5, 0);
        chk("t5.peak_max", int'(bus.peak_max), 300);
        chk("t5.peak_min", int'(bus.peak_min), -20);
        chk("t5.peaks_valid", int'(bus.peaks_valid), 1);
        step(1, 1, 7, 1);
        chk("t5.clr_smp_max", int'(bus.peak_max), 7);
        chk("t5.clr_smp_min", int'(bus.peak_min), 7);
        step(1, 0, 0, 1);
        chk("t5.clr_max", int'(bus.peak_max), MOST_NEG);
        chk("t5.clr_min", int'(bus.peak_min), MOST_POS);
        chk("t5.clr_valid", int'(bus.peaks_valid), 0);

        // Async reset in the middle of a pending rise.
        step(1, 1, 150, 0);
        step(1, 1, 150, 0);
        step(1, 0, 0, 0);
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk_reset("async_reset");
        model_reset();
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        step(1, 1, 150, 0);
        step(1, 1, 150, 0);
        chk("t6.no_rise", int'(bus.rise_pulse), 0);
        chk("t6.level_low", int'(bus.level_high), 0);
        step(1, 1, 0, 0);

        // Random traffic, including occasional misconfigured thresholds and
        // confirm_cnt changes in the middle of a pending run.
        for (int i = 0; i < 3000; i++) begin
            int s;
            if (i % 200 == 0) begin
                bus.thr_high = 16'($urandom_range(200) - 50);
                bus.thr_low  = 16'(-int'($urandom_range(200)) + 50);
            end
            if ($urandom_range(99) < 3) bus.confirm_cnt = 4'($urandom_range(6));
            case ($urandom_range(19))
                0:       s = MOST_NEG;
                1:       s = MOST_POS;
                default: s = int'($urandom_range(600)) - 300;
            endcase
            step($urandom_range(9) != 0, $urandom_range(9) < 6, s, $urandom_range(99) < 3);
        end

        for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(negedge clk);
        #1;
        chk("scoreboard_drained", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
